// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP string-match engine: character width,
// controller state encoding and an address-width helper.
package kmp_pkg;

   localparam int CHAR_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      BUILD    = 3'd2,
      SCAN_REQ = 3'd3,
      SCAN_CMP = 3'd4,
      DONE     = 3'd5
   } state_t;

   // Width of an index into an n-entry table, never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kmp_prefix_table.sv
// KMP failure-function builder: one comparison step per clock after start,
// done stays high once every entry of the table has been produced.
module kmp_prefix_table
   import kmp_pkg::*;
#(
   parameter int PAT_LEN = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [PAT_LEN*CHAR_W-1:0]              pat_vec,
   output logic                                   done,
   output logic [PAT_LEN*$clog2(PAT_LEN+1)-1:0]   fail_vec
);

   localparam int FW = $clog2(PAT_LEN + 1);
   localparam int IW = idx_w(PAT_LEN);
   localparam logic [FW-1:0] LAST = FW'(PAT_LEN);

   logic [CHAR_W-1:0] pat    [PAT_LEN];
   logic [FW-1:0]     fail_r [PAT_LEN];
   logic [FW-1:0]     i;
   logic [FW-1:0]     k;
   logic              active;
   logic              step;
   logic              same;

   always_comb begin
      for (int unsigned j = 0; j < PAT_LEN; j++) begin
         pat[j]                = pat_vec[j*CHAR_W +: CHAR_W];
         fail_vec[j*FW +: FW]  = fail_r[j];
      end
   end

   assign step = active && (i != LAST);
   assign same = (pat[IW'(i)] == pat[IW'(k)]);
   assign done = active && (i == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         i      <= '0;
         k      <= '0;
      end else if (start) begin
         active <= 1'b1;
         i      <= FW'(1);
         k      <= '0;
      end else if (step) begin
         if (same) begin
            i <= i + 1'b1;
            k <= k + 1'b1;
         end else if (k != '0) begin
            k <= fail_r[IW'(k - 1'b1)];
         end else begin
            i <= i + 1'b1;
         end
      end
   end

   // Table contents are only meaningful after a completed build, so no reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (start) begin
            fail_r[0] <= '0;
         end else if (step) begin
            if (same) begin
               fail_r[IW'(i)] <= k + 1'b1;
            end else if (k == '0) begin
               fail_r[IW'(i)] <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/kmp_engine.sv
// KMP substring counter: loads the pattern, builds its prefix table, then
// scans a text range counting overlapping or non-overlapping matches.
module kmp_engine
   import kmp_pkg::*;
#(
   parameter int PAT_LEN = 4,
   parameter int ADDR_W  = 14,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inicio,
   input  logic                       sel,
   input  logic [ADDR_W-1:0]          start_addr,
   input  logic [ADDR_W-1:0]          text_end,
   output logic [idx_w(PAT_LEN)-1:0]  pat_addr,
   input  logic [CHAR_W-1:0]          pat_data,
   output logic [ADDR_W-1:0]          text_addr,
   input  logic [CHAR_W-1:0]          text_data,
   output logic [CNT_W-1:0]           instancias,
   output logic                       busy,
   output logic                       done,
   output logic                       sat
);

   localparam int FW = $clog2(PAT_LEN + 1);
   localparam int IW = idx_w(PAT_LEN);
   localparam logic [FW-1:0] LAST    = FW'(PAT_LEN);
   localparam logic [FW-1:0] LAST_M1 = FW'(PAT_LEN - 1);

   state_t                   state;
   logic [CHAR_W-1:0]        pat    [PAT_LEN];
   logic [FW-1:0]            fail_a [PAT_LEN];
   logic [PAT_LEN*CHAR_W-1:0] pat_vec;
   logic [PAT_LEN*FW-1:0]    fail_vec;
   logic [FW-1:0]            lc;
   logic [FW-1:0]            q;
   logic [ADDR_W-1:0]        cur;
   logic [ADDR_W-1:0]        end_r;
   logic                     sel_r;
   logic                     pt_start;
   logic                     pt_done;
   logic                     hit;
   logic                     last_char;

   always_comb begin
      for (int unsigned j = 0; j < PAT_LEN; j++) begin
         pat_vec[j*CHAR_W +: CHAR_W] = pat[j];
         fail_a[j]                   = fail_vec[j*FW +: FW];
      end
   end

   assign pt_start  = (state == LOAD) && (lc == LAST);
   assign hit       = (text_data == pat[IW'(q)]);
   assign last_char = (({1'b0, cur} + 1'b1) == {1'b0, end_r});
   assign busy      = (state == LOAD) || (state == BUILD) ||
                      (state == SCAN_REQ) || (state == SCAN_CMP);
   assign done      = (state == DONE);

   kmp_prefix_table #(
      .PAT_LEN (PAT_LEN)
   ) u_prefix (
      .clk      (clk),
      .rst      (rst),
      .start    (pt_start),
      .pat_vec  (pat_vec),
      .done     (pt_done),
      .fail_vec (fail_vec)
   );

   // pat_data lags pat_addr by one cycle, so entry lc-1 arrives while lc is current.
   always_ff @(posedge clk) begin
      if (state == LOAD && lc != '0) begin
         pat[IW'(lc - 1'b1)] <= pat_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         instancias <= '0;
         sat        <= 1'b0;
         pat_addr   <= '0;
         text_addr  <= '0;
         q          <= '0;
         lc         <= '0;
         cur        <= '0;
         end_r      <= '0;
         sel_r      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (inicio) begin
                  instancias <= '0;
                  sat        <= 1'b0;
                  sel_r      <= sel;
                  cur        <= start_addr;
                  end_r      <= text_end;
                  pat_addr   <= '0;
                  lc         <= '0;
                  q          <= '0;
                  state      <= (start_addr >= text_end) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (lc == LAST) begin
                  state <= BUILD;
               end else begin
                  lc <= lc + 1'b1;
                  if (lc != LAST_M1) begin
                     pat_addr <= IW'(lc + 1'b1);
                  end
               end
            end
            BUILD: begin
               if (pt_done) begin
                  text_addr <= cur;
                  q         <= '0;
                  state     <= SCAN_REQ;
               end
            end
            SCAN_REQ: begin
               state <= SCAN_CMP;
            end
            SCAN_CMP: begin
               if (hit) begin
                  if (q == LAST_M1) begin
                     if (&instancias) begin
                        sat <= 1'b1;
                     end else begin
                        instancias <= instancias + 1'b1;
                     end
                     q <= sel_r ? '0 : fail_a[PAT_LEN-1];
                  end else begin
                     q <= q + 1'b1;
                  end
               end else if (q != '0) begin
                  q <= fail_a[IW'(q - 1'b1)];
               end
               // A fallback keeps text_addr (and hence text_data) parked on cur.
               if (hit || q == '0) begin
                  if (last_char) begin
                     state <= DONE;
                  end else begin
                     cur       <= cur + 1'b1;
                     text_addr <= cur + 1'b1;
                     state     <= SCAN_REQ;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kmp_engine.sv
// Directed bench for kmp_engine: a brute-force substring counter and a
// brute-force border table serve as the reference for two configurations.
module tb_kmp_engine;
   import kmp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        inicio_a, sel_a, busy_a, done_a, sat_a;
   logic [13:0] start_addr_a, text_end_a, text_addr_a;
   logic [1:0]  pat_addr_a;
   logic [7:0]  pat_data_a, text_data_a, instancias_a;

   logic        inicio_b, sel_b, busy_b, done_b, sat_b;
   logic [5:0]  start_addr_b, text_end_b, text_addr_b;
   logic [0:0]  pat_addr_b;
   logic [7:0]  pat_data_b, text_data_b;
   logic [1:0]  instancias_b;

   logic [7:0] pat_mem_a  [4];
   logic [7:0] text_mem_a [64];
   logic [7:0] pat_mem_b  [2];
   logic [7:0] text_mem_b [64];

   int    checks = 0;
   int    errors = 0;
   bit    mon_a = 1'b0;
   bit    mon_b = 1'b0;
   int    exp_cnt_a, exp_cnt_b;
   bit    exp_sat_a, exp_sat_b;
   string pat_cur_a = "ABAB";

   kmp_engine #(.PAT_LEN(4), .ADDR_W(14), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .inicio(inicio_a), .sel(sel_a),
      .start_addr(start_addr_a), .text_end(text_end_a),
      .pat_addr(pat_addr_a), .pat_data(pat_data_a),
      .text_addr(text_addr_a), .text_data(text_data_a),
      .instancias(instancias_a), .busy(busy_a), .done(done_a), .sat(sat_a)
   );

   kmp_engine #(.PAT_LEN(1), .ADDR_W(6), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .inicio(inicio_b), .sel(sel_b),
      .start_addr(start_addr_b), .text_end(text_end_b),
      .pat_addr(pat_addr_b), .pat_data(pat_data_b),
      .text_addr(text_addr_b), .text_data(text_data_b),
      .instancias(instancias_b), .busy(busy_b), .done(done_b), .sat(sat_b)
   );

   // Synchronous-read memories: data valid one cycle after the address.
   always @(posedge clk) begin
      pat_data_a  <= pat_mem_a[pat_addr_a];
      text_data_a <= text_mem_a[text_addr_a[5:0]];
      pat_data_b  <= pat_mem_b[pat_addr_b];
      text_data_b <= text_mem_b[text_addr_b];
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] char_at(input string t, input int i);
      if (i < t.len()) return t[i];
      return 8'h2E;
   endfunction

   // Leftmost-first scan; non-overlapping mode resumes after a whole match.
   function automatic int model_count(input string p, input string t, input int s, input int e, input bit nonov);
      int c = 0;
      int pos = s;
      int len = p.len();
      while (pos + len <= e) begin
         bit ok = 1'b1;
         for (int j = 0; j < len; j++) if (char_at(t, pos + j) != p[j]) ok = 1'b0;
         if (ok) begin
            c++;
            pos = pos + (nonov ? len : 1);
         end else begin
            pos++;
         end
      end
      return c;
   endfunction

   // Length of the longest proper border of p[0..i].
   function automatic int model_fail(input string p, input int i);
      for (int len = i; len >= 1; len--) begin
         bit ok = 1'b1;
         for (int j = 0; j < len; j++) if (p[j] != p[i - len + 1 + j]) ok = 1'b0;
         if (ok) return len;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check("busy_done_excl_a", {busy_a, done_a} == 2'b11, 0);
         check("busy_done_excl_b", {busy_b, done_b} == 2'b11, 0);
      end
      if (mon_a) begin
         check("done_a", done_a, 1);
         check("busy_a", busy_a, 0);
         check("count_a", instancias_a, exp_cnt_a);
         check("sat_a", sat_a, exp_sat_a);
         for (int j = 0; j < 4; j++) check("fail_a", dut_a.fail_vec[j*3 +: 3], model_fail(pat_cur_a, j));
      end
      if (mon_b) begin
         check("done_b", done_b, 1);
         check("count_b", instancias_b, exp_cnt_b);
         check("sat_b", sat_b, exp_sat_b);
      end
   end

   task automatic load_a(input string p, input string t, input int s, input int e, input bit sl);
      for (int i = 0; i < 4; i++) pat_mem_a[i] = p[i];
      for (int i = 0; i < 64; i++) text_mem_a[i] = char_at(t, i);
      start_addr_a = 14'(s);
      text_end_a   = 14'(e);
      sel_a        = sl;
      pat_cur_a    = p;
   endtask

   task automatic run_a(input string p, input string t, input int s, input int e, input bit sl, input int poke);
      int n = 0;
      int c;
      load_a(p, t, s, e, sl);
      @(negedge clk) inicio_a = 1'b1;
      @(negedge clk) inicio_a = 1'b0;
      while (!done_a && n < 2000) begin
         @(negedge clk);
         n++;
         inicio_a = 1'b0;
         sel_a = sl;
         start_addr_a = 14'(s);
         if (poke > 0 && n % poke == 0 && busy_a) begin
            inicio_a = 1'b1;
            sel_a = ~sl;
            start_addr_a = '0;
         end
      end
      inicio_a = 1'b0;
      sel_a = sl;
      start_addr_a = 14'(s);
      check("done_timeout_a", done_a, 1);
      c = model_count(p, t, s, e, sl);
      exp_cnt_a = (c > 255) ? 255 : c;
      exp_sat_a = (c > 255);
      mon_a = 1'b1;
      repeat (3) @(negedge clk);
      mon_a = 1'b0;
   endtask

   task automatic run_b(input string p, input string t, input int s, input int e);
      int n = 0;
      int c;
      pat_mem_b[0] = p[0];
      pat_mem_b[1] = p[0];
      for (int i = 0; i < 64; i++) text_mem_b[i] = char_at(t, i);
      start_addr_b = 6'(s);
      text_end_b   = 6'(e);
      sel_b        = 1'b0;
      @(negedge clk) inicio_b = 1'b1;
      @(negedge clk) inicio_b = 1'b0;
      while (!done_b && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout_b", done_b, 1);
      c = model_count(p, t, s, e, 1'b0);
      exp_cnt_b = (c > 3) ? 3 : c;
      exp_sat_b = (c > 3);
      mon_b = 1'b1;
      repeat (3) @(negedge clk);
      mon_b = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      inicio_a = 1'b0; sel_a = 1'b0; start_addr_a = '0; text_end_a = '0;
      inicio_b = 1'b0; sel_b = 1'b0; start_addr_b = '0; text_end_b = '0;
      for (int i = 0; i < 4; i++) pat_mem_a[i] = '0;
      for (int i = 0; i < 2; i++) pat_mem_b[i] = '0;
      for (int i = 0; i < 64; i++) begin
         text_mem_a[i] = '0;
         text_mem_b[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_count_a", instancias_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_sat_a", sat_a, 0);
      check("rst_text_addr_a", text_addr_a, 0);
      check("rst_done_b", done_b, 0);
      rst = 1'b0;

      run_a("ABAB", "ABABAB", 0, 6, 1'b0, 0);
      check("abab_overlap", instancias_a, 2);
      run_a("ABAB", "ABABAB", 0, 6, 1'b1, 0);
      check("abab_nonoverlap", instancias_a, 1);

      run_a("AABA", "AABAABAAABAAB", 0, 13, 1'b0, 0);
      check("aaba_fail0", dut_a.fail_vec[2:0], 0);
      check("aaba_fail1", dut_a.fail_vec[5:3], 1);
      check("aaba_fail2", dut_a.fail_vec[8:6], 0);
      check("aaba_fail3", dut_a.fail_vec[11:9], 1);
      check("aaba_count", instancias_a, 3);

      run_a("AAAA", "AAAAAAAAAAAAAAAAAAAA", 3, 15, 1'b0, 0);
      check("aaaa_overlap", instancias_a, 9);
      run_a("AAAA", "AAAAAAAAAAAAAAAAAAAA", 3, 15, 1'b1, 0);
      check("aaaa_nonoverlap", instancias_a, 3);
      run_a("ABCA", "xABCABCAxABCA", 0, 13, 1'b0, 0);
      run_a("ABCA", "xABCABCAxABCA", 0, 13, 1'b1, 0);
      run_a("ABAB", "ABABAB", 4, 6, 1'b0, 0);
      check("short_range", instancias_a, 0);

      // Start pulses while busy must leave the run undisturbed.
      run_a("ABAB", "ABABABABAB", 0, 10, 1'b0, 3);
      check("poked_count", instancias_a, 4);

      // Reset in the middle of a comparison, then rerun.
      load_a("ABAB", "ABABABABAB", 0, 10, 1'b0);
      @(negedge clk) inicio_a = 1'b1;
      @(negedge clk) inicio_a = 1'b0;
      repeat (12) @(negedge clk);
      n = 0;
      while (dut_a.state != SCAN_CMP && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reach_scan_cmp", dut_a.state == SCAN_CMP, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_state", int'(dut_a.state), int'(IDLE));
      check("midrst_count", instancias_a, 0);
      check("midrst_busy", busy_a, 0);
      check("midrst_done", done_a, 0);
      check("midrst_sat", sat_a, 0);
      check("midrst_pat_addr", pat_addr_a, 0);
      check("midrst_text_addr", text_addr_a, 0);
      check("midrst_cur", dut_a.cur, 0);
      check("midrst_q", dut_a.q, 0);
      rst = 1'b0;
      run_a("ABAB", "ABABABABAB", 0, 10, 1'b0, 0);
      check("after_rst_count", instancias_a, 4);

      // Empty range goes straight to DONE without touching text memory.
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      start_addr_a = 14'd5;
      text_end_a   = 14'd5;
      @(negedge clk) inicio_a = 1'b1;
      @(negedge clk) inicio_a = 1'b0;
      check("empty_busy1", busy_a, 0);
      @(negedge clk);
      check("empty_done2", done_a, 1);
      check("empty_count", instancias_a, 0);
      for (int i = 0; i < 3; i++) begin
         check("empty_text_addr", text_addr_a, 0);
         check("empty_busy", busy_a, 0);
         @(negedge clk);
      end

      run_b("A", "AAAAAAA", 0, 7);
      check("single_sat_count", instancias_b, 3);
      check("single_sat_flag", sat_b, 1);
      run_b("A", "ABBA", 0, 4);
      check("single_count", instancias_b, 2);
      check("single_sat_clear", sat_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kmp_engine.md
KMP_ENGINE -- requirements
Module: kmp_engine

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, meaning pattern length in characters (1..16).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning text address width.
REQ-003 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port inicio, input, 1, start pulse.
REQ-007 SHALL have port sel, input, 1, match mode: 0 overlapping, 1 non-overlapping; sampled on accepted inicio.
REQ-008 SHALL have port start_addr, input, ADDR_W, first text address; sampled on accepted inicio.
REQ-009 SHALL have port text_end, input, ADDR_W, exclusive end address; sampled on accepted inicio.
REQ-010 SHALL have port pat_addr, output, $clog2(PAT_LEN) (min 1), pattern memory address.
REQ-011 SHALL have port pat_data, input, 8, pattern character, valid one cycle after pat_addr.
REQ-012 SHALL have port text_addr, output, ADDR_W, text memory address.
REQ-013 SHALL have port text_data, input, 8, text character, valid one cycle after text_addr.
REQ-014 SHALL have port instancias, output, CNT_W, match count.
REQ-015 SHALL have ports busy, done, sat, outputs, 1 each; sat means count saturated.

Function
REQ-016 SHALL implement states IDLE, LOAD, BUILD, SCAN_REQ, SCAN_CMP, DONE.
REQ-017 SHALL accept inicio only in IDLE or DONE; inicio in other states is ignored.
REQ-018 On accepted inicio: count 0, sat 0, done 0; go to DONE next cycle if start_addr >= text_end, else LOAD.
REQ-019 LOAD: drive pat_addr 0..PAT_LEN-1 on consecutive cycles; store each pat_data one cycle later; PAT_LEN+1 cycles total, then BUILD.
REQ-020 BUILD: compute prefix table fail[0..PAT_LEN-1], fail[0]=0, one step per cycle with i=1, k=0.
REQ-021 BUILD step: if pat[i]==pat[k] then fail[i]=k+1, k++, i++; else if k>0 then k=fail[k-1]; else fail[i]=0, i++.
REQ-022 BUILD SHALL exit to SCAN_REQ when i==PAT_LEN; PAT_LEN=1 exits after one cycle.
REQ-023 SCAN_REQ: drive text_addr=cur (cur initialised to start_addr), then go to SCAN_CMP; q initialised to 0 at BUILD exit.
REQ-024 SCAN_CMP: text_addr SHALL stay at cur, so text_data remains stable across fallback cycles.
REQ-025 Equal and q+1<PAT_LEN: q++, advance.
REQ-026 Equal and q+1==PAT_LEN: match; count +1 unless all ones, in which case set sat and hold count; q = sel ? 0 : fail[PAT_LEN-1]; advance.
REQ-027 Mismatch and q>0: q=fail[q-1]; stay in SCAN_CMP.
REQ-028 Mismatch and q==0: advance.
REQ-029 Advance: if cur+1==text_end go to DONE, else cur++ and go to SCAN_REQ.
REQ-030 cur SHALL never wrap; text_end == 2^ADDR_W is not representable and is not supported.
REQ-031 busy SHALL be 1 in LOAD, BUILD, SCAN_REQ and SCAN_CMP; done SHALL be 1 only in DONE.
REQ-032 DONE SHALL hold instancias and sat until the next accepted inicio or rst.

Reset
REQ-033 rst SHALL take priority over inicio in the same cycle.
REQ-034 rst SHALL force the following on the next edge, including mid-operation: state IDLE, instancias 0, sat/busy/done 0, pat_addr 0, text_addr 0, q/k/i/cur 0.
REQ-035 Pattern and prefix-table registers need not be reset.

Structure
REQ-036 A shared package kmp_pkg SHALL hold the state enum and CHAR_W=8.
REQ-037 The BUILD logic SHALL be one sub-module, kmp_prefix_table, with start/done handshake and a fail[] vector output.

Verification
REQ-038 Pattern "ABAB", text "ABABAB", start 0, end 6, sel=0: done with instancias=2; with sel=1: instancias=1.
REQ-039 Pattern "AABA": fail table SHALL equal {0,1,0,1} at BUILD exit.
REQ-040 PAT_LEN=1, CNT_W=2, pattern "A", text "AAAAAAA": instancias=3, sat=1.
REQ-041 start_addr=5, text_end=5: done=1 two cycles after inicio, instancias=0, no text_addr activity.
REQ-042 rst asserted mid-SCAN_CMP: next cycle IDLE, outputs 0; restart then yields the correct count.
REQ-043 inicio pulsed during SCAN: ignored; final count unchanged versus an undisturbed run.
